// File: rtl/frame_pixel_writer.sv
// Validates incoming frame dimensions, converts parser pixels to RGB444, buffers them
// in a small FIFO and writes them to the frame buffer at raster addresses.
module frame_pixel_writer #(
    parameter int unsigned MAX_W      = 320,
    parameter int unsigned MAX_H      = 240,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    input  logic              pix_valid,
    input  logic [15:0]       height,
    input  logic [15:0]       width,
    input  logic              dim_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_data,
    output logic              mem_we,
    output logic              frame_done,
    output logic              dim_error,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic [2:0]        state;
    logic [15:0]       w_q;
    logic [15:0]       h_q;
    logic [15:0]       col;
    logic [15:0]       row;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] line_base;
    logic              last_pending;

    logic [11:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic        accepting;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        drop;
    logic        at_eol;
    logic        at_last;
    logic        dims_bad;
    logic [11:0] entry;

    always_comb begin
        accepting  = (state == S_CHECK) || (state == S_RUN);
        fifo_empty = (count == '0);
        fifo_full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
        // Once the last pixel has been popped, anything left in the FIFO is surplus.
        pop        = (state == S_RUN) && !fifo_empty && mem_ready && !last_pending;
        push       = pix_valid && accepting && (!fifo_full || pop);
        drop       = pix_valid && ((state == S_IDLE) || (state == S_DONE) ||
                                   (accepting && fifo_full && !pop));
        at_eol     = (col == w_q - 16'd1);
        at_last    = at_eol && (row == h_q - 16'd1);
        dims_bad   = (w_q == 16'd0) || (h_q == 16'd0) ||
                     (32'(w_q) > MAX_W) || (32'(h_q) > MAX_H);
        entry      = {pix_r[7:4], pix_g[7:4], pix_b[7:4]};
        busy       = accepting;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            w_q          <= '0;
            h_q          <= '0;
            col          <= '0;
            row          <= '0;
            addr         <= '0;
            line_base    <= '0;
            last_pending <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_we       <= 1'b0;
            frame_done   <= 1'b0;
            dim_error    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            mem_we     <= pop;
            frame_done <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                mem_data <= fifo_mem[rd_ptr];
                mem_addr <= addr;
                rd_ptr   <= rd_ptr + PTR_W'(1);
                // Line stride is MAX_W, so the next row starts one stride past line_base.
                if (at_eol) begin
                    col       <= '0;
                    row       <= row + 16'd1;
                    addr      <= line_base + ADDR_W'(MAX_W);
                    line_base <= line_base + ADDR_W'(MAX_W);
                end else begin
                    col  <= col + 16'd1;
                    addr <= addr + ADDR_W'(1);
                end
                if (at_last) begin
                    last_pending <= 1'b1;
                end
            end

            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (dim_valid) begin
                        w_q   <= width;
                        h_q   <= height;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (dims_bad) begin
                        dim_error <= 1'b1;
                        state     <= S_ERROR;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Last write is on the bus this cycle; done follows one cycle later.
                    if (last_pending) begin
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pixel_writer.sv
// Directed bench for frame_pixel_writer: raster addressing, conversion, latency,
// backpressure, dimension errors, mid-frame reset and post-frame overflow.
module tb_frame_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic        pix_valid;
    logic [15:0] height, width;
    logic        dim_valid;
    logic        mem_ready;
    logic [16:0] mem_addr;
    logic [11:0] mem_data;
    logic        mem_we;
    logic        frame_done;
    logic        dim_error;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int k;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cyc  [$];

    frame_pixel_writer dut (
        .clk        (clk),
        .reset      (reset),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .pix_valid  (pix_valid),
        .height     (height),
        .width      (width),
        .dim_valid  (dim_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .frame_done (frame_done),
        .dim_error  (dim_error),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(32'(mem_addr));
            wr_data.push_back(32'(mem_data));
            wr_cyc.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wa(input int i);
        return (wr_addr.size() > i) ? wr_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wd(input int i);
        return (wr_data.size() > i) ? wr_data[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pix_valid = 1'b0;
        dim_valid = 1'b0;
        pix_r = '0; pix_g = '0; pix_b = '0;
        width = '0; height = '0;
        repeat (2) tick();
        reset = 1'b0;
        clear_log();
    endtask

    // Returns in the CHECK cycle.
    task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
        width     = w;
        height    = h;
        dim_valid = 1'b1;
        tick();
        dim_valid = 1'b0;
    endtask

    task automatic send_pix(input logic [23:0] p);
        {pix_r, pix_g, pix_b} = p;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
    endtask

    initial begin
        mem_ready = 1'b1;
        do_reset();

        // Reset state
        check("rst_flags", {27'd0, mem_we, frame_done, dim_error, overflow, busy}, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);

        // 2x2 frame, pixels 3 cycles apart
        start_frame(16'd2, 16'd2);
        check("busy_check", 32'(busy), 32'd1);
        send_pix(24'h102030); repeat (2) tick();
        send_pix(24'h405060); repeat (2) tick();
        send_pix(24'h708090); repeat (2) tick();
        send_pix(24'hA0B0C0);
        repeat (6) tick();
        check("f2_nwr", 32'(wr_addr.size()), 32'd4);
        check("f2_a0", wa(0), 32'd0);
        check("f2_d0", wd(0), 32'h123);
        check("f2_a1", wa(1), 32'd1);
        check("f2_d1", wd(1), 32'h456);
        check("f2_a2", wa(2), 32'd320);
        check("f2_d2", wd(2), 32'h789);
        check("f2_a3", wa(3), 32'd321);
        check("f2_d3", wd(3), 32'hABC);
        check("f2_done_cnt", 32'(done_cnt), 32'd1);
        check("f2_done_cyc", 32'(done_cyc - ((wr_cyc.size() == 4) ? wr_cyc[3] : 0)), 32'd1);
        check("f2_busy", 32'(busy), 32'd0);

        // 1x1 latency and conversion
        do_reset();
        start_frame(16'd1, 16'd1);
        tick();
        k = cyc;
        send_pix(24'hABCDEF);
        repeat (4) tick();
        check("lat_nwr", 32'(wr_addr.size()), 32'd1);
        check("lat_cyc", 32'((wr_cyc.size() > 0) ? wr_cyc[0] - k : -1), 32'd2);
        check("lat_data", wd(0), 32'hACE);
        check("lat_addr", wa(0), 32'd0);
        check("lat_done", 32'(done_cnt), 32'd1);

        // Backpressure 3x2
        do_reset();
        mem_ready = 1'b0;
        start_frame(16'd3, 16'd2);
        for (int i = 1; i <= 5; i++) send_pix(24'h111111 * i);
        check("bp_ovf", 32'(overflow), 32'd1);
        check("bp_nwr0", 32'(wr_addr.size()), 32'd0);
        mem_ready = 1'b1;
        repeat (8) tick();
        check("bp_nwr", 32'(wr_addr.size()), 32'd4);
        check("bp_a0", wa(0), 32'd0);
        check("bp_a1", wa(1), 32'd1);
        check("bp_a2", wa(2), 32'd2);
        check("bp_a3", wa(3), 32'd320);
        check("bp_d3", wd(3), 32'h444);
        check("bp_done", 32'(done_cnt), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);

        // Width too large
        do_reset();
        start_frame(16'd321, 16'd10);
        check("de_w_early", 32'(dim_error), 32'd0);
        tick();
        check("de_w", 32'(dim_error), 32'd1);
        send_pix(24'h123456);
        send_pix(24'h654321);
        repeat (3) tick();
        check("de_w_nwr", 32'(wr_addr.size()), 32'd0);
        check("de_w_ovf", 32'(overflow), 32'd0);
        check("de_w_busy", 32'(busy), 32'd0);

        // Zero width
        do_reset();
        start_frame(16'd0, 16'd5);
        tick();
        check("de_z", 32'(dim_error), 32'd1);
        send_pix(24'h123456);
        repeat (3) tick();
        check("de_z_nwr", 32'(wr_addr.size()), 32'd0);

        // Reset mid-frame 4x4
        do_reset();
        start_frame(16'd4, 16'd4);
        for (int i = 0; i < 5; i++) begin
            send_pix(24'h0F0F0F);
            tick();
        end
        repeat (3) tick();
        check("mr_nwr", 32'(wr_addr.size()), 32'd5);
        check("mr_a4", wa(4), 32'd320);
        mem_ready = 1'b0;
        send_pix(24'hFFFFFF);
        send_pix(24'hEEEEEE);
        reset     = 1'b1;
        mem_ready = 1'b1;
        tick();
        check("mr_flags", {27'd0, mem_we, frame_done, dim_error, overflow, busy}, 32'd0);
        check("mr_addr", 32'(mem_addr), 32'd0);
        check("mr_data", 32'(mem_data), 32'd0);
        reset = 1'b0;
        repeat (4) tick();
        check("mr_no_we", 32'(wr_addr.size()), 32'd5);

        clear_log();
        start_frame(16'd1, 16'd1);
        send_pix(24'h123456);
        repeat (4) tick();
        check("mr_new_nwr", 32'(wr_addr.size()), 32'd1);
        check("mr_new_addr", wa(0), 32'd0);
        check("mr_new_data", wd(0), 32'h135);
        check("mr_new_ovf", 32'(overflow), 32'd0);

        // Post-frame pixel
        send_pix(24'h777777);
        repeat (3) tick();
        check("pf_ovf", 32'(overflow), 32'd1);
        check("pf_nwr", 32'(wr_addr.size()), 32'd1);
        check("pf_done", 32'(done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_pixel_writer.md
Name: frame_pixel_writer

Overview:
- Sits directly downstream of the UART byte parser that emits height, width, a level "dimensions received" flag and per-pixel 24-bit RGB with a one-cycle ready pulse.
- Validates the frame dimensions and converts each pixel to RGB444.
- Buffers pixels in a small FIFO and writes them into the VGA frame-buffer BRAM at raster addresses with a fixed line stride.
- Reports frame completion and error conditions to the top-level controller.

Parameters:
MAX_W, 320, maximum accepted width; also the frame-buffer line stride
MAX_H, 240, maximum accepted height
ADDR_W, 17, frame-buffer address width (must satisfy MAX_W*MAX_H <= 2^ADDR_W)
FIFO_DEPTH, 4, pixel buffer entries (power of two)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_r  in  8  red component from parser
pix_g  in  8  green component from parser
pix_b  in  8  blue component from parser
pix_valid  in  1  one-cycle pulse; pixel inputs valid this cycle
height  in  16  frame height in lines
width  in  16  frame width in pixels
dim_valid  in  1  level; height/width stable while high
mem_ready  in  1  frame buffer write port available this cycle
mem_addr  out  ADDR_W  write address, registered
mem_data  out  12  RGB444 write data, registered
mem_we  out  1  one-cycle write strobe, registered
frame_done  out  1  one-cycle pulse after last pixel written
dim_error  out  1  sticky: dimensions invalid
overflow  out  1  sticky: pixel dropped
busy  out  1  frame in progress

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - All outputs are 0.
  - FIFO is empty.
  - Row, column and address counters are 0.
  - State is IDLE.
  - Reset mid-frame aborts the frame immediately; no write is issued in the following cycle.
- State machine:
  - IDLE:
    - On the first cycle with dim_valid=1, latch width/height and go to CHECK.
    - Any pix_valid in IDLE is discarded and sets overflow.
  - CHECK (one cycle):
    - If width==0, height==0, width>MAX_W or height>MAX_H: go to ERROR and set dim_error=1.
    - Otherwise go to RUN.
    - A pix_valid arriving in CHECK is accepted into the FIFO.
  - RUN:
    - Accept pixels into the FIFO and drain them to memory.
    - When the last pixel (col==W-1, row==H-1) is written, go to DONE.
  - DONE: terminal until reset. pix_valid is discarded and sets overflow.
  - ERROR: terminal until reset. All pixels are discarded, mem_we stays 0, overflow is not set.
- Conversion at FIFO push: entry = {pix_r[7:4], pix_g[7:4], pix_b[7:4]}.
- FIFO push:
  - pix_valid in CHECK or RUN pushes when not full.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted and occupancy is unchanged.
  - If the FIFO is full with no pop, the pixel is dropped and overflow is set. The raster position does not advance for a dropped pixel.
- Pop and write:
  - In RUN with the FIFO non-empty and mem_ready=1, pop the head.
  - On the next edge register mem_we=1, mem_data=head and mem_addr=current address, then advance the counters. mem_we is 0 in every other cycle.
- Address generation (no multiplier):
  - Address starts at 0.
  - Within a line, address+1 and col+1.
  - At col==W-1: col=0, row+1, address = line_base+MAX_W, where line_base tracks the address of column 0 of the current row.
- Latency: with the FIFO empty and mem_ready held high, a pix_valid in cycle k yields mem_we=1 in cycle k+2.
- frame_done:
  - Asserted for exactly one cycle, the cycle after mem_we for the last pixel.
  - Also the first cycle in DONE.
- busy: 1 in CHECK, and in RUN until frame_done; 0 otherwise.
- dim_valid is not re-sampled after IDLE. Dimension changes mid-frame are ignored.

Test Plan:
- 2x2 frame, mem_ready=1, pixels 0x102030, 0x405060, 0x708090, 0xA0B0C0 spaced 3 cycles apart:
  - Writes are addr 0/0x123, 1/0x456, 320/0x789, 321/0xABC.
  - frame_done pulses once, one cycle after the 4th mem_we.
  - busy then drops.
- Latency and conversion: a 1x1 frame with pixel 0xABCDEF in cycle k gives mem_we=1 in cycle k+2 with mem_data=0xACE and addr 0.
- Backpressure, 3x2 frame, mem_ready=0:
  - Five back-to-back pix_valid pulses: the first four are buffered, the 5th is dropped and overflow=1.
  - Raise mem_ready: four writes at addr 0,1,2,320; no frame_done.
- Dimension errors:
  - width=321, height=10 leads to dim_error=1 two cycles after dim_valid; subsequent pixels produce no mem_we.
  - width=0 gives the same result.
- Reset mid-frame:
  - 4x4 frame; assert reset after 5 writes, with 2 pixels still queued.
  - No mem_we follows; all outputs are 0.
  - A new 1x1 frame afterwards writes to addr 0.
- Post-frame pixel: after a completed 1x1 frame, one extra pix_valid sets overflow=1 with no mem_we and no second frame_done.
